// File: rtl/fetch_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// fetch_hazard_controller_if
// Bundles the hazard inputs and the fetch/pipeline control outputs of the
// fetch hazard controller.
//   master : pipeline side (drives hazard sources, receives controls)
//   slave  : controller side (receives hazard sources, drives controls)
// Signals:
//   id_rs1, id_rs2 [4:0]  source registers of the instruction in ID
//   ex_rd [4:0]           destination register of the instruction in EX
//   ex_mem_read           EX holds a load
//   ex_branch, ALU_zero   EX holds a branch / its condition
//   imem_ready            instruction word valid this cycle
//   halt_req              level request to stop and drain
//   PC_write, branch_taken, ifid_write, ifid_flush, idex_flush, halted
//   state [1:0]           debug view of the FSM
//   stall_cnt, flush_cnt  performance counters, CNT_W bits
// ---------------------------------------------------------------------------
interface fetch_hazard_controller_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_branch;
  logic             ALU_zero;
  logic             imem_ready;
  logic             halt_req;
  logic             PC_write;
  logic             branch_taken;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic             halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch, ALU_zero,
           imem_ready, halt_req,
    input  PC_write, branch_taken, ifid_write, ifid_flush, idex_flush,
           halted, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch, ALU_zero,
           imem_ready, halt_req,
    output PC_write, branch_taken, ifid_write, ifid_flush, idex_flush,
           halted, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_hazard_controller.sv
// ---------------------------------------------------------------------------
// fetch_hazard_controller
// Sequences the fetch stage and the IF/ID, ID/EX pipeline registers: PC
// advance, IF/ID load/hold/flush, ID/EX bubble, taken-branch redirect and
// the halt/drain sequence. Control outputs are combinational from the
// registered FSM state and the current inputs.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_hazard_controller_if.slave (hazard inputs, control outputs)
// Parameters:
//   FLUSH_CYCLES (1..7) bubble cycles after a taken branch incl. redirect
//   DRAIN_CYCLES (1..7) cycles for EX/MEM/WB to empty before halting
//   CNT_W               performance counter width
// Build option:
//   HAZARD_PERF_CNT_EN  defined: saturating stall/flush counters are built;
//                       undefined: stall_cnt/flush_cnt are constant 0.
// ---------------------------------------------------------------------------
module fetch_hazard_controller #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  fetch_hazard_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

  state_t     state_reg;
  logic [2:0] cnt_reg;

  logic load_use;
  logic take_branch;

  assign load_use    = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                       ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
  assign take_branch = bus.ex_branch && bus.ALU_zero;

  // Next-state sequencing; cnt is shared by FLUSH and DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      cnt_reg   <= 3'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (take_branch) begin
            if (FLUSH_CYCLES > 1) begin
              state_reg <= FLUSH;
              cnt_reg   <= FLUSH_INIT;
            end
          end else if (bus.halt_req) begin
            state_reg <= DRAIN;
            cnt_reg   <= DRAIN_INIT;
          end
        end
        FLUSH: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) state_reg <= RUN;
        end
        DRAIN: begin
          cnt_reg <= cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) state_reg <= HALTED;
        end
        default: state_reg <= HALTED;
      endcase
    end
  end

  // Control decode. Rule priority in RUN: branch, halt, load-use, fetch wait.
  always_comb begin
    bus.PC_write     = 1'b0;
    bus.branch_taken = 1'b0;
    bus.ifid_write   = 1'b1;
    bus.ifid_flush   = 1'b0;
    bus.idex_flush   = 1'b0;
    bus.halted       = 1'b0;
    if (rst) begin
      // Hold the front end empty until reset is released.
      bus.ifid_write = 1'b0;
      bus.ifid_flush = 1'b1;
      bus.idex_flush = 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          if (take_branch) begin
            // Redirect always takes, even if imem is not ready.
            bus.branch_taken = 1'b1;
            bus.PC_write     = 1'b1;
            bus.ifid_flush   = 1'b1;
            bus.idex_flush   = 1'b1;
          end else if (bus.halt_req) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
          end else if (load_use) begin
            bus.ifid_write = 1'b0;
            bus.idex_flush = 1'b1;
          end else if (!bus.imem_ready) begin
            bus.ifid_flush = 1'b1;
          end else begin
            bus.PC_write = 1'b1;
          end
        end
        FLUSH: begin
          bus.PC_write   = bus.imem_ready;
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
        end
        DRAIN: begin
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
        end
        default: begin
          bus.halted     = 1'b1;
          bus.ifid_flush = 1'b1;
          bus.idex_flush = 1'b1;
        end
      endcase
    end
  end

  assign bus.state = state_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic             stall_inc;
  logic             flush_inc;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  assign stall_inc = (state_reg == RUN) && !take_branch && !bus.halt_req &&
                     (load_use || !bus.imem_ready);
  assign flush_inc = ((state_reg == RUN) && take_branch) || (state_reg == FLUSH);

  // Saturating counters; HALTED never raises either increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && (stall_cnt_reg != {CNT_W{1'b1}}))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_inc && (flush_cnt_reg != {CNT_W{1'b1}}))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_reg;
  assign bus.flush_cnt = flush_cnt_reg;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_hazard_controller
// Scoreboard bench: each driven cycle pushes the expected controls, computed
// from a behavioural model of the sequencing rules, and the negedge monitor
// pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_fetch_hazard_controller;
  localparam int FC    = 3;
  localparam int DC    = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct {
    logic          pc_write;
    logic          branch_taken;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_flush;
    logic          halted;
    logic [1:0]    state;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  exp_t exp_q[$];

  int m_state = 0;
  int m_cnt   = 0;
  int m_stall = 0;
  int m_flush = 0;

  fetch_hazard_controller_if #(.CNT_W(CW)) bus ();

  fetch_hazard_controller #(
    .FLUSH_CYCLES(FC),
    .DRAIN_CYCLES(DC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, want, txn);
    end
  endtask

  task automatic bump(inout int c);
`ifdef HAZARD_PERF_CNT_EN
    if (c < CMAX) c++;
`endif
  endtask

  // Drive one cycle of inputs, push expectation, advance the model.
  task automatic step(input logic r, input logic b, input logic z, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic rdy, input logic h);
    exp_t e;
    logic lu, br;
    @(posedge clk);
    #1;
    rst = r;
    bus.ex_branch = b; bus.ALU_zero = z; bus.ex_mem_read = mr;
    bus.ex_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2;
    bus.imem_ready = rdy; bus.halt_req = h;
    if (r) begin
      m_state = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    end
    lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    br = b && z;
    e.pc_write = 1'b0; e.branch_taken = 1'b0; e.ifid_write = 1'b1;
    e.ifid_flush = 1'b0; e.idex_flush = 1'b0; e.halted = 1'b0;
    e.state = 2'(m_state); e.stall = CW'(m_stall); e.flush = CW'(m_flush);
    if (r) begin
      e.ifid_write = 1'b0; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
    end else begin
      case (m_state)
        0: begin
          if (br) begin
            e.pc_write = 1'b1; e.branch_taken = 1'b1;
            e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
            bump(m_flush);
            if (FC > 1) begin m_state = 1; m_cnt = FC - 1; end
          end else if (h) begin
            e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
            m_state = 2; m_cnt = DC;
          end else if (lu) begin
            e.ifid_write = 1'b0; e.idex_flush = 1'b1;
            bump(m_stall);
          end else if (!rdy) begin
            e.ifid_flush = 1'b1;
            bump(m_stall);
          end else begin
            e.pc_write = 1'b1;
          end
        end
        1: begin
          e.pc_write = rdy; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
          bump(m_flush);
          if (m_cnt == 1) m_state = 0;
          m_cnt--;
        end
        2: begin
          e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
          if (m_cnt == 1) m_state = 3;
          m_cnt--;
        end
        default: begin
          e.halted = 1'b1; e.ifid_flush = 1'b1; e.idex_flush = 1'b1;
        end
      endcase
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      txn++;
      check_eq("PC_write",     32'(bus.PC_write),     32'(e.pc_write));
      check_eq("branch_taken", 32'(bus.branch_taken), 32'(e.branch_taken));
      check_eq("ifid_write",   32'(bus.ifid_write),   32'(e.ifid_write));
      check_eq("ifid_flush",   32'(bus.ifid_flush),   32'(e.ifid_flush));
      check_eq("idex_flush",   32'(bus.idex_flush),   32'(e.idex_flush));
      check_eq("halted",       32'(bus.halted),       32'(e.halted));
      check_eq("state",        32'(bus.state),        32'(e.state));
      check_eq("stall_cnt",    32'(bus.stall_cnt),    32'(e.stall));
      check_eq("flush_cnt",    32'(bus.flush_cnt),    32'(e.flush));
      $display("txn %0d: state=%0d pc_write=%0b ifid_w=%0b ifid_f=%0b idex_f=%0b bt=%0b halted=%0b stall=%0d flush=%0d",
               txn, bus.state, bus.PC_write, bus.ifid_write, bus.ifid_flush,
               bus.idex_flush, bus.branch_taken, bus.halted, bus.stall_cnt, bus.flush_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.ex_rd = 0; bus.ex_mem_read = 0;
    bus.ex_branch = 0; bus.ALU_zero = 0; bus.imem_ready = 1; bus.halt_req = 0;

    // Reset held, then released with no hazards.
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(3);

    // Load-use on rs2, then clear; ex_rd=0 never stalls; load-use on rs1.
    step(0, 0, 0, 1, 5, 1, 5, 1, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 7, 7, 2, 1, 0);
    step(0, 0, 0, 0, 7, 7, 7, 1, 0);

    // Fetch wait for 4 cycles; load-use outranks fetch wait.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 3, 0, 0, 0);
    idle(1);

    // Taken branch held through FLUSH (ignored there), then RUN.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0, 1, 0);
    idle(1);
    // Branch not taken; taken branch with imem not ready in FLUSH.
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 4, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);

    // Branch + load-use + fetch wait + halt: branch wins, halt waits.
    step(0, 1, 1, 1, 6, 6, 6, 0, 1);
    step(0, 1, 1, 0, 0, 0, 0, 1, 1);
    step(0, 1, 1, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);   // halt accepted
    step(0, 1, 1, 0, 0, 0, 0, 1, 0);   // DRAIN cnt=3
    step(0, 0, 0, 1, 9, 9, 0, 0, 1);   // DRAIN cnt=2

    // Asynchronous reset mid-DRAIN.
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_state",  32'(bus.state),    32'd0);
    check_eq("async_halted", 32'(bus.halted),   32'd0);
    check_eq("async_pcw",    32'(bus.PC_write), 32'd0);
    m_state = 0; m_cnt = 0; m_stall = 0; m_flush = 0;
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(2);

    // Counter saturation under a long fetch wait.
    for (int i = 0; i < CMAX + 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Full halt: accept, drain, then terminal HALTED ignoring inputs.
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < DC; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 8, 8, 8, 0, 1);
    idle(2);

    @(negedge clk);
    #1;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
